apb_master: RTL and testbench

APB requester (initiator) bridging a simple valid/ready command/response interface onto the APB bus.
- Issues one APB transfer per command using the standard SETUP -> ACCESS sequence.
- Tolerates any number of slave wait states.
- Returns read data and error status on a response channel.
- Sits between the local controller/testbench driver and apb_ram or any other APB completer.

---
 rtl/apb_master.sv | 151 +++++++++++++++
 tb/tb_apb_master.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// ============================================================================
// Module   : apb_master
// Brief    : APB requester bridging a valid/ready command/response interface
//            onto APB. Optional ACCESS-phase timeout via `APB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_master #(
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [DATA_WIDTH-1:0] c_timeout_data = DATA_WIDTH'(32'hDEADBEEF);

  state_t r_state;
  state_t w_next;
  logic   w_timeout;

`ifdef APB_TIMEOUT_EN
  localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_cnt_w-1:0] r_to_cnt;

  // Counts stalled ACCESS cycles; the abort fires on the stalled cycle that
  // would bring the count to TIMEOUT_CYCLES.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_to_cnt <= '0;
    end else if (r_state == S_SETUP) begin
      r_to_cnt <= '0;
    end else if (r_state == S_ACCESS && !pready) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == S_ACCESS) && !pready &&
                     (r_to_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign w_timeout            = 1'b0;
`endif

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:   w_next = cmd_valid ? S_SETUP : S_IDLE;
      S_SETUP:  w_next = S_ACCESS;
      S_ACCESS: w_next = (pready || w_timeout) ? S_RESP : S_ACCESS;
      S_RESP:   w_next = rsp_ready ? S_IDLE : S_RESP;
      default:  w_next = S_IDLE;
    endcase
  end

  // Bus and response registers; address/data hold until the next accept.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            pwrite  <= cmd_write;
            paddr   <= cmd_addr;
            pwdata  <= cmd_wdata;
            psel    <= 1'b1;
            penable <= 1'b0;
          end
        end
        S_SETUP: begin
          penable <= 1'b1;
        end
        S_ACCESS: begin
          if (pready) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_err   <= pslverr;
            rsp_rdata <= pwrite ? '0 : prdata;
            rsp_valid <= 1'b1;
          end else if (w_timeout) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_err   <= 1'b1;
            rsp_rdata <= c_timeout_data;
            rsp_valid <= 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          psel    <= 1'b0;
          penable <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_apb_master.sv
// ============================================================================
// Module   : tb_apb_master
// Brief    : Directed self-checking bench for apb_master with a small APB
//            memory completer. Timeout scenario runs when APB_TIMEOUT_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_master;

  localparam int ADDR_WIDTH     = 5;
  localparam int DATA_WIDTH     = 32;
  localparam int TIMEOUT_CYCLES = 16;

  logic                  pclk;
  logic                  presetn;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;
  logic                  busy;

  logic                  use_mem;
  logic [DATA_WIDTH-1:0] tb_prdata;
  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  int n_cmp = 0;
  int n_err = 0;

  apb_master #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .DATA_WIDTH     (DATA_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .busy      (busy)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Minimal APB memory completer; prdata can be overridden per step.
  assign prdata = use_mem ? mem[paddr] : tb_prdata;
  always @(posedge pclk) begin
    if (psel && penable && pready && pwrite) mem[paddr] <= pwdata;
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_WIDTH); i++) mem[i] = '0;
    presetn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    pready    = 1'b1;
    pslverr   = 1'b0;
    use_mem   = 1'b1;
    tb_prdata = '0;

    // Reset state
    tick(); tick();
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    presetn = 1'b1;
    tick();

    // Write 0x0A <- 0x12345678, no wait states
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'h0A; cmd_wdata = 32'h12345678;
    chk("w_cmd_ready_idle", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    chk("w_setup_psel", psel, 1);
    chk("w_setup_penable", penable, 0);
    chk("w_setup_paddr", paddr, 5'h0A);
    chk("w_setup_pwdata", pwdata, 32'h12345678);
    chk("w_setup_cmd_ready", cmd_ready, 0);
    tick();
    chk("w_access_psel", psel, 1);
    chk("w_access_penable", penable, 1);
    chk("w_access_rsp_valid", rsp_valid, 0);
    tick();
    chk("w_resp_psel", psel, 0);
    chk("w_resp_penable", penable, 0);
    chk("w_rsp_valid", rsp_valid, 1);
    chk("w_rsp_err", rsp_err, 0);
    chk("w_rsp_rdata", rsp_rdata, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("w_done_rsp_valid", rsp_valid, 0);
    chk("w_done_cmd_ready", cmd_ready, 1);

    // Read back 0x0A from memory
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'h0A; cmd_wdata = 32'hFFFFFFFF;
    tick();
    cmd_valid = 1'b0;
    cmd_addr  = 5'h01;
    chk("r_setup_paddr", paddr, 5'h0A);
    chk("r_setup_pwrite", pwrite, 0);
    tick();
    chk("r_access_paddr", paddr, 5'h0A);
    chk("r_access_pwrite", pwrite, 0);
    chk("r_access_penable", penable, 1);
    tick();
    chk("r_rsp_valid", rsp_valid, 1);
    chk("r_rsp_rdata", rsp_rdata, 32'h12345678);
    chk("r_rsp_err", rsp_err, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Read with three wait states; prdata/pslverr noise before pready
    use_mem = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'h03;
    tick();
    cmd_valid = 1'b0;
    pready = 1'b0; pslverr = 1'b1; tb_prdata = 32'hBAD0BAD0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("ws_penable_%0d", i), penable, 1);
      chk($sformatf("ws_psel_%0d", i), psel, 1);
      chk($sformatf("ws_paddr_%0d", i), paddr, 5'h03);
      chk($sformatf("ws_cmd_ready_%0d", i), cmd_ready, 0);
      chk($sformatf("ws_rsp_valid_%0d", i), rsp_valid, 0);
    end
    pready = 1'b1; pslverr = 1'b0; tb_prdata = 32'hA5A50003;
    tick();
    chk("ws_rsp_valid", rsp_valid, 1);
    chk("ws_rsp_rdata", rsp_rdata, 32'hA5A50003);
    chk("ws_rsp_err", rsp_err, 0);
    chk("ws_penable_done", penable, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Completer error on a read
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'h11;
    pslverr = 1'b1; tb_prdata = 32'hDEADBEEF;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    chk("err_rsp_valid", rsp_valid, 1);
    chk("err_rsp_err", rsp_err, 1);
    chk("err_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    pslverr = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Response back-pressure with a pending command
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'h1F; cmd_wdata = 32'hCAFEF00D;
    tick();
    cmd_write = 1'b0; cmd_addr = 5'h05; cmd_wdata = 32'h0;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_rsp_valid_%0d", i), rsp_valid, 1);
      chk($sformatf("bp_rsp_rdata_%0d", i), rsp_rdata, 0);
      chk($sformatf("bp_rsp_err_%0d", i), rsp_err, 0);
      chk($sformatf("bp_psel_%0d", i), psel, 0);
      chk($sformatf("bp_cmd_ready_%0d", i), cmd_ready, 0);
      chk($sformatf("bp_paddr_%0d", i), paddr, 5'h1F);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_hs_rsp_valid", rsp_valid, 0);
    chk("bp_hs_cmd_ready", cmd_ready, 1);
    chk("bp_hs_psel", psel, 0);
    chk("bp_hs_pwrite_held", pwrite, 1);
    tick();
    chk("bp_next_psel", psel, 1);
    chk("bp_next_paddr", paddr, 5'h05);
    chk("bp_next_pwrite", pwrite, 0);
    cmd_valid = 1'b0;
    pready = 1'b0;

    // Asynchronous reset in the middle of ACCESS
    tick(); tick();
    chk("ar_pre_penable", penable, 1);
    #2;
    presetn = 1'b0;
    #1;
    chk("ar_psel", psel, 0);
    chk("ar_penable", penable, 0);
    chk("ar_rsp_valid", rsp_valid, 0);
    chk("ar_busy", busy, 0);
    chk("ar_paddr", paddr, 0);
    tick();
    presetn = 1'b1;
    pready  = 1'b1;
    tick(); tick();
    chk("ar_after_cmd_ready", cmd_ready, 1);
    chk("ar_after_rsp_valid", rsp_valid, 0);
    chk("ar_after_psel", psel, 0);

`ifdef APB_TIMEOUT_EN
    // Completer never responds
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'h07;
    tb_prdata = 32'h0;
    tick();
    cmd_valid = 1'b0;
    pready = 1'b0;
    tick();
    for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) begin
      tick();
      chk($sformatf("to_penable_%0d", i), penable, 1);
      chk($sformatf("to_rsp_valid_%0d", i), rsp_valid, 0);
    end
    tick();
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("to_psel", psel, 0);
    pready = 1'b1;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("to_cmd_ready", cmd_ready, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
